mul_issue_ctrl: RTL and testbench
=================================

Name: mul_issue_ctrl

Overview:
Upstream sequencer for the iterative 32x32 signed multiplier. Buffers operand pairs from a valid/ready producer in a small FIFO and presents one pair at a time on x/y. Drives the multiplier's level-sensitive mul enable, watches complete, and captures the 64-bit product into a valid/ready output register with a tag. A watchdog flags a multiplier that never completes.

Parameters:
DEPTH, 2, operand FIFO entries (power of two, >=2)
TAG_W, 4, width of the transaction tag carried alongside operands
TIMEOUT, 127, maximum RUN cycles before an error result is forced

Ports:
mul_clk  in  1  clock, all state on posedge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  FIFO can accept
in_x  in  32  multiplicand
in_y  in  32  multiplier operand
in_tag  in  TAG_W  transaction tag
mul  out  1  multiplier enable, level
x  out  32  operand to multiplier
y  out  32  operand to multiplier
complete  in  1  multiplier done pulse/level
result  in  64  multiplier product
out_valid  out  1  product valid
out_ready  in  1  consumer accepts
out_result  out  64  captured product
out_tag  out  TAG_W  tag of captured product
out_err  out  1  product forced by timeout
busy  out  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Reset: mul_clk single clock. Reset is asynchronous, active-high, and clears all state immediately: FIFO empty, FSM=IDLE, mul=0, x=y=0, out_valid=0, out_result=0, out_tag=0, out_err=0, timer=0. in_ready=0 while reset is high, then 1.
- FIFO:
  - Push when in_valid&in_ready. in_ready = !full, with no bypass.
  - Full with a simultaneous pop: no push, because in_ready was low. Empty with a push: the entry is visible to the FSM on the next cycle.
  - Pointers wrap modulo DEPTH. Occupancy counter is width clog2(DEPTH)+1.
- FSM states: IDLE, SETUP, RUN, RECOVER.
  - IDLE: if FIFO is non-empty and (!out_valid | out_ready), pop the head into the op register (x, y, tag) and go to SETUP. Otherwise stay.
  - SETUP: mul=0 for exactly one cycle so the multiplier registers the operand sign bits, then RUN. complete is ignored in SETUP.
  - RUN: mul=1 and timer increments from 1.
    - complete=1: capture result into out_result, set out_tag, out_err=0, out_valid=1, then RECOVER.
    - Else if timer==TIMEOUT: out_result=0, out_err=1, out_valid=1, then RECOVER.
    - complete and timeout in the same cycle: complete wins.
  - RECOVER: mul=0 for one cycle, which re-arms the multiplier's counter. Clear timer, then IDLE.
- x and y change only on the pop edge and are held stable through SETUP, RUN and RECOVER.
- Output register:
  - out_valid clears on out_valid&out_ready.
  - The issue condition guarantees out_valid=0 at capture, so a capture never overwrites an unconsumed product.
  - out_result, out_tag and out_err stay stable while out_valid=1 and out_ready=0.
- Latency, push into empty FIFO at edge t0:
  - t1: pop, enter SETUP.
  - t2: RUN, mul=1.
  - If complete is first high during cycle t2+k-1, out_valid=1 after edge t2+k.
  - Back-to-back throughput is one product per L+3 cycles.
- Reset mid-RUN aborts the operation with no output. mul drops asynchronously.

Decomposition:
- Package mul_pkg: FSM state enum (2 bits), operand width constant 32, product width constant 64.
- One sub-module: mul_op_fifo (parameterised DEPTH/width, valid/ready push, pop strobe, full/empty). The FSM and output register stay in mul_issue_ctrl.
- Bench uses a behavioural multiplier model with programmable latency L.

Test Plan:
- Single op, L=5: x=0x00000003, y=0xFFFFFFFE, tag=1 -> mul high cycles t2..t6 and out_result=0xFFFFFFFFFFFFFFFA with out_tag=1 and out_err=0 after edge t7. mul=0 in the RECOVER cycle.
- FIFO full: push 3 ops with out_ready=0 and DEPTH=2 -> in_ready=0 after the FIFO holds 2 entries (first op in flight). The third op waits; no overwrite occurs; order and tags are preserved on drain.
- Backpressure: first product held with out_ready=0 for 10 cycles -> out_result/out_tag are stable, no second pop happens, and the pop occurs on the out_ready edge.
- Timeout: model never asserts complete, TIMEOUT=127 -> after 127 RUN cycles out_valid=1, out_err=1, out_result=0, then the next op issues normally.
- complete and timeout collide: complete first rises on RUN cycle 127 -> out_err=0 and the real product is captured.
- Async reset asserted mid-RUN at a non-edge time -> mul, out_valid and busy drop immediately, and in_ready is 0 until reset deasserts and 1 afterwards. A fresh op after reset completes correctly.

Source files
------------

// File: rtl/mul_issue_ctrl_pkg.sv
// Shared types and widths for the multiplier issue sequencer.
package mul_pkg;

  localparam int OP_W   = 32;
  localparam int PROD_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_RUN     = 2'd2,
    ST_RECOVER = 2'd3
  } mul_state_e;

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Operand-in, multiplier-side and product-out signals of the issue sequencer.
interface mul_issue_ctrl_if #(
  parameter int TAG_W = 4
);

  logic                        in_valid;
  logic                        in_ready;
  logic [mul_pkg::OP_W-1:0]    in_x;
  logic [mul_pkg::OP_W-1:0]    in_y;
  logic [TAG_W-1:0]            in_tag;

  logic                        mul;
  logic [mul_pkg::OP_W-1:0]    x;
  logic [mul_pkg::OP_W-1:0]    y;
  logic                        complete;
  logic [mul_pkg::PROD_W-1:0]  result;

  logic                        out_valid;
  logic                        out_ready;
  logic [mul_pkg::PROD_W-1:0]  out_result;
  logic [TAG_W-1:0]            out_tag;
  logic                        out_err;
  logic                        busy;

  modport slave (
    input  in_valid, in_x, in_y, in_tag, complete, result, out_ready,
    output in_ready, mul, x, y, out_valid, out_result, out_tag, out_err, busy
  );

  modport master (
    output in_valid, in_x, in_y, in_tag, complete, result, out_ready,
    input  in_ready, mul, x, y, out_valid, out_result, out_tag, out_err, busy
  );

endinterface

// File: rtl/mul_issue_ctrl_fifo.sv
// Operand FIFO: registered storage, push visible to the reader one cycle later,
// push_rdy = !full (held low during reset), no push/pop bypass.
module mul_op_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 68
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld,
  output logic         push_rdy,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign push_rdy = !full && !rst;
  assign do_push  = push_vld && push_rdy;
  assign do_pop   = pop && !empty;
  assign pop_dat  = mem_q[rd_ptr_q];

  // Pointers are power-of-two wide, so plain increment wraps modulo DEPTH.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Sequences buffered operand pairs through the iterative multiplier: pop, SETUP, RUN (mul=1) until
// complete or timeout, RECOVER; one product per L+3 cycles, no pop while an unconsumed product is held.
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 127
) (
  input logic              mul_clk,
  input logic              reset,
  mul_issue_ctrl_if.slave  bus
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int FW    = TAG_W + 2 * OP_W;

  mul_state_e        state_q, state_d;
  logic [OP_W-1:0]   x_q, x_d;
  logic [OP_W-1:0]   y_q, y_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              out_vld_q, out_vld_d;
  logic [PROD_W-1:0] out_res_q, out_res_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;
  logic              out_err_q, out_err_d;

  logic              fifo_pop;
  logic              fifo_empty;
  logic [FW-1:0]     fifo_dat;

  mul_op_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk      (mul_clk),
    .rst      (reset),
    .push_vld (bus.in_valid),
    .push_rdy (bus.in_ready),
    .push_dat ({bus.in_tag, bus.in_y, bus.in_x}),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    tag_d     = tag_q;
    timer_d   = timer_q;
    out_vld_d = out_vld_q;
    out_res_d = out_res_q;
    out_tag_d = out_tag_q;
    out_err_d = out_err_q;
    fifo_pop  = 1'b0;

    if (out_vld_q && bus.out_ready) begin
      out_vld_d = 1'b0;
    end

    case (state_q)
      // Issuing only when the output slot is free (or freeing now) means capture never overwrites.
      ST_IDLE: begin
        if (!fifo_empty && (!out_vld_q || bus.out_ready)) begin
          fifo_pop            = 1'b1;
          {tag_d, y_d, x_d}   = fifo_dat;
          state_d             = ST_SETUP;
        end
      end
      ST_SETUP: begin
        timer_d = TMR_W'(1);
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.complete) begin
          out_res_d = bus.result;
          out_tag_d = tag_q;
          out_err_d = 1'b0;
          out_vld_d = 1'b1;
          state_d   = ST_RECOVER;
        end else if (timer_q == TMR_W'(TIMEOUT)) begin
          out_res_d = '0;
          out_tag_d = tag_q;
          out_err_d = 1'b1;
          out_vld_d = 1'b1;
          state_d   = ST_RECOVER;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_RECOVER: begin
        timer_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge mul_clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      tag_q     <= '0;
      timer_q   <= '0;
      out_vld_q <= 1'b0;
      out_res_q <= '0;
      out_tag_q <= '0;
      out_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      tag_q     <= tag_d;
      timer_q   <= timer_d;
      out_vld_q <= out_vld_d;
      out_res_q <= out_res_d;
      out_tag_q <= out_tag_d;
      out_err_q <= out_err_d;
    end
  end

  // mul decodes straight from the state flop so an async reset drops it at once.
  assign bus.mul        = (state_q == ST_RUN);
  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.out_valid  = out_vld_q;
  assign bus.out_result = out_res_q;
  assign bus.out_tag    = out_tag_q;
  assign bus.out_err    = out_err_q;
  assign bus.busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Scoreboard bench for mul_issue_ctrl with a behavioural multiplier of programmable latency.
module tb_mul_issue_ctrl;
  import mul_pkg::*;

  localparam int TAG_W = 4;

  typedef struct packed {
    logic [63:0]      res;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  logic mul_clk = 1'b0;
  logic reset   = 1'b0;
  always #5 mul_clk = ~mul_clk;

  mul_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

  mul_issue_ctrl #(
    .DEPTH   (2),
    .TAG_W   (TAG_W),
    .TIMEOUT (127)
  ) dut (
    .mul_clk (mul_clk),
    .reset   (reset),
    .bus     (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb_;
    sa  = {{32{a[31]}}, a};
    sb_ = {{32{b[31]}}, b};
    return sa * sb_;
  endfunction

  // Multiplier model: complete asserts in the lat-th consecutive mul-high cycle.
  int         lat        = 5;
  bit         never_done = 1'b0;
  logic [7:0] mcnt;

  always_ff @(posedge mul_clk or posedge reset) begin
    if (reset)        mcnt <= '0;
    else if (bus.mul) mcnt <= mcnt + 8'd1;
    else              mcnt <= '0;
  end

  assign bus.complete = bus.mul && !never_done && (int'(mcnt) == lat - 1);
  assign bus.result   = prod(bus.x, bus.y);

  always @(negedge mul_clk) begin
    exp_t e;
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", 64'(bus.out_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check("out_result", bus.out_result, e.res);
        check("out_tag", 64'(bus.out_tag), 64'(e.tag));
        check("out_err", 64'(bus.out_err), 64'(e.err));
      end
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic push(input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] t, input logic err);
    exp_t e;
    int   w;
    bus.in_valid = 1'b1;
    bus.in_x     = a;
    bus.in_y     = b;
    bus.in_tag   = t;
    w = 0;
    @(negedge mul_clk);
    while (!bus.in_ready && w < 400) begin
      @(negedge mul_clk);
      w++;
    end
    check("push_accept", 64'(bus.in_ready), 64'd1);
    @(posedge mul_clk);
    e.res = err ? 64'd0 : prod(a, b);
    e.tag = t;
    e.err = err;
    sb.push_back(e);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int w;
    w = 0;
    @(negedge mul_clk);
    while ((bus.busy || bus.out_valid || sb.size() != 0) && w < 1000) begin
      @(negedge mul_clk);
      w++;
    end
    check({name, "_busy"}, 64'(bus.busy), 64'd0);
    check({name, "_sb"}, 64'(sb.size()), 64'd0);
    @(posedge mul_clk);
    #1;
  endtask

  task automatic count_run(input string name, input int exp_cycles);
    int n;
    int w;
    n = 0;
    w = 0;
    @(negedge mul_clk);
    while (!bus.out_valid && w < 400) begin
      if (bus.mul) n++;
      @(negedge mul_clk);
      w++;
    end
    check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({name, "_run_cycles"}, 64'(n), 64'(exp_cycles));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  mulv;
    logic [7:0]  ovv;
    logic [31:0] ax[4];
    logic [31:0] ay[4];
    logic [63:0] held_res;
    logic [63:0] held_tag;
    int          w;

    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #1 reset = 1'b1;
    #11;
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_mul", 64'(bus.mul), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_result", bus.out_result, 64'd0);
    check("rst_out_tag", 64'(bus.out_tag), 64'd0);
    check("rst_out_err", 64'(bus.out_err), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_xy", 64'({bus.x, bus.y}), 64'd0);
    @(negedge mul_clk);
    reset = 1'b0;
    #1;
    check("rst_in_ready_after", 64'(bus.in_ready), 64'd1);
    @(posedge mul_clk);
    #1;

    // Single op, L=5: cycle-accurate mul/out_valid profile
    lat = 5;
    push(32'h0000_0003, 32'hFFFF_FFFE, 4'd1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge mul_clk);
      mulv[i] = bus.mul;
      ovv[i]  = bus.out_valid;
      if (i == 3) check("t1_xy_hold", {bus.x, bus.y}, 64'h0000_0003_FFFF_FFFE);
      if (i == 7) begin
        check("t1_result", bus.out_result, 64'hFFFF_FFFF_FFFF_FFFA);
        check("t1_tag", 64'(bus.out_tag), 64'd1);
        check("t1_busy_recover", 64'(bus.busy), 64'd1);
      end
    end
    check("t1_mul_profile", 64'(mulv), 64'h7C);
    check("t1_valid_profile", 64'(ovv), 64'h80);
    wait_idle("t1");

    // FIFO full plus output backpressure
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ax[i] = $urandom;
      ay[i] = $urandom;
    end
    push(ax[0], ay[0], 4'd2, 1'b0);
    push(ax[1], ay[1], 4'd3, 1'b0);
    push(ax[2], ay[2], 4'd4, 1'b0);
    @(negedge mul_clk);
    check("t2_in_ready_full", 64'(bus.in_ready), 64'd0);
    fork
      push(ax[3], ay[3], 4'd5, 1'b0);
    join_none
    w = 0;
    while (!bus.out_valid && w < 100) begin
      @(negedge mul_clk);
      w++;
    end
    check("t3_first_valid", 64'(bus.out_valid), 64'd1);
    held_res = bus.out_result;
    held_tag = 64'(bus.out_tag);
    check("t3_first_value", held_res, prod(ax[0], ay[0]));
    for (int i = 0; i < 10; i++) begin
      @(negedge mul_clk);
      check("t3_hold_result", bus.out_result, held_res);
      check("t3_hold_tag", 64'(bus.out_tag), held_tag);
      check("t3_no_pop", 64'(bus.x), 64'(ax[0]));
      check("t3_fifo_full", 64'(bus.in_ready), 64'd0);
    end
    @(posedge mul_clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge mul_clk);
    @(negedge mul_clk);
    check("t3_pop_on_ready_x", 64'(bus.x), 64'(ax[1]));
    check("t3_pop_on_ready_mul", 64'(bus.mul), 64'd0);
    wait_idle("t2");

    // Timeout: multiplier never completes
    never_done = 1'b1;
    push(32'h1234_5678, 32'h0000_0010, 4'd6, 1'b1);
    count_run("t4", 127);
    check("t4_err", 64'(bus.out_err), 64'd1);
    wait_idle("t4");
    never_done = 1'b0;
    lat = 5;
    push(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd7, 1'b0);
    wait_idle("t4_next");

    // complete on the same RUN cycle as the timeout
    lat = 127;
    push(32'h8000_0000, 32'h0000_0002, 4'd8, 1'b0);
    count_run("t5", 127);
    check("t5_err", 64'(bus.out_err), 64'd0);
    wait_idle("t5");

    // Async reset mid-RUN
    lat = 5;
    push(32'd11, 32'd13, 4'd9, 1'b0);
    w = 0;
    @(negedge mul_clk);
    while (!bus.mul && w < 20) begin
      @(negedge mul_clk);
      w++;
    end
    check("t6_in_run", 64'(bus.mul), 64'd1);
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    check("t6_mul_drop", 64'(bus.mul), 64'd0);
    check("t6_valid_drop", 64'(bus.out_valid), 64'd0);
    check("t6_busy_drop", 64'(bus.busy), 64'd0);
    check("t6_in_ready_rst", 64'(bus.in_ready), 64'd0);
    @(negedge mul_clk);
    check("t6_in_ready_rst2", 64'(bus.in_ready), 64'd0);
    @(negedge mul_clk);
    reset = 1'b0;
    #1;
    check("t6_in_ready_after", 64'(bus.in_ready), 64'd1);
    @(posedge mul_clk);
    #1;
    push(32'hFFFF_FFF9, 32'd6, 4'd10, 1'b0);
    wait_idle("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
